// File: rtl/ct_hpcp_pkg.sv
// Shared constants, sequencer state encoding and index decode for the HPM
// event-select write controller.
package ct_hpcp_pkg;

  localparam int EVT_NUM      = 29;
  localparam int HPMEVT_WIDTH = 10;
  localparam int HPMCNT_NUM   = 49;
  localparam int IDX_BASE     = 3;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_CLR  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // CSR index (3..31) to one-hot register select; indices below the base decode to zero.
  function automatic logic [EVT_NUM-1:0] idx2onehot(input logic [4:0] idx);
    logic [EVT_NUM-1:0] oh;
    oh = '0;
    for (int i = 0; i < EVT_NUM; i++) begin
      if (idx == 5'(i + IDX_BASE)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/ct_hpcp_evt_ctrl_if.sv
// Request/response bundle between the write sources and the event-register write controller.
// Handshakes: csr_wr_vld is a single-cycle pulse that is always taken; dbg_wr_req is held
// until dbg_wr_ack is seen high for one cycle; clr_req is a pulse ignored while clr_busy.
interface ct_hpcp_evt_ctrl_if;
  import ct_hpcp_pkg::*;

  logic                csr_wr_vld;
  logic [4:0]          csr_wr_idx;
  logic [63:0]         csr_wr_data;
  logic                dbg_wr_req;
  logic [4:0]          dbg_wr_idx;
  logic [63:0]         dbg_wr_data;
  logic                dbg_wr_ack;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;
  logic [EVT_NUM-1:0]  evt_wen;
  logic [EVT_NUM-1:0]  evt_clk_en;
  logic [63:0]         evt_wdata;
  logic                evt_illegal;
  seq_state_e          clr_state;

  modport master (
    output csr_wr_vld, csr_wr_idx, csr_wr_data,
    output dbg_wr_req, dbg_wr_idx, dbg_wr_data,
    output clr_req,
    input  dbg_wr_ack, clr_busy, clr_done,
    input  evt_wen, evt_clk_en, evt_wdata, evt_illegal, clr_state
  );

  modport slave (
    input  csr_wr_vld, csr_wr_idx, csr_wr_data,
    input  dbg_wr_req, dbg_wr_idx, dbg_wr_data,
    input  clr_req,
    output dbg_wr_ack, clr_busy, clr_done,
    output evt_wen, evt_clk_en, evt_wdata, evt_illegal, clr_state
  );

endinterface

// File: rtl/ct_hpcp_evt_clr_seq.sv
// Bulk-clear sequencer: walks ptr over every event register, writing 0 whenever the
// arbiter grants it, then pulses done for one cycle.
module ct_hpcp_evt_clr_seq
  import ct_hpcp_pkg::*;
(
  input  logic       eventx_clk,
  input  logic       cpurst_b,
  input  logic       i_clr_req,
  input  logic       i_grant,
  output logic       o_req,
  output logic [4:0] o_ptr,
  output logic       o_busy,
  output logic       o_done,
  output seq_state_e o_state
);

  seq_state_e r_state;
  seq_state_e w_state_nxt;
  logic [4:0] r_ptr;
  logic [4:0] w_ptr_nxt;

  always_ff @(posedge eventx_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= SEQ_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    o_req       = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = SEQ_CLR;
          w_ptr_nxt   = '0;
        end
      end
      SEQ_CLR: begin
        o_req = 1'b1;
        // Without a grant the pointer holds, so a stalled register is retried.
        if (i_grant) begin
          if (r_ptr == 5'(EVT_NUM - 1)) begin
            w_state_nxt = SEQ_DONE;
            w_ptr_nxt   = '0;
          end else begin
            w_ptr_nxt = r_ptr + 5'd1;
          end
        end
      end
      SEQ_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = SEQ_IDLE;
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  assign o_ptr   = r_ptr;
  assign o_busy  = (r_state != SEQ_IDLE);
  assign o_state = r_state;

endmodule

// File: rtl/ct_hpcp_evt_ctrl.sv
// Event-select register write controller: fixed-priority arbiter (CSR > debug > clear
// sequencer), one-hot decode and registered write bus. Debug port enabled by HPCP_EVT_DBG_WR_EN.
module ct_hpcp_evt_ctrl
  import ct_hpcp_pkg::*;
(
  input  logic               eventx_clk,
  input  logic               cpurst_b,
  ct_hpcp_evt_ctrl_if.slave  bus
);

  logic               w_csr_gnt;
  logic               w_dbg_gnt;
  logic               w_seq_req;
  logic               w_seq_gnt;
  logic [4:0]         w_seq_ptr;
  logic [4:0]         w_sel_idx;
  logic [63:0]        w_sel_data;
  logic [EVT_NUM-1:0] w_sel_oh;
  logic               w_wr_vld;
  logic               w_illegal;

  logic [EVT_NUM-1:0] r_evt_wen;
  logic [63:0]        r_evt_wdata;
  logic               r_evt_illegal;

  // CSR writes to indices below the base are dropped and do not block lower sources.
  assign w_csr_gnt = bus.csr_wr_vld & (bus.csr_wr_idx >= 5'(IDX_BASE));

`ifdef HPCP_EVT_DBG_WR_EN
  assign w_dbg_gnt = bus.dbg_wr_req & ~w_csr_gnt;
`else
  logic w_dbg_unused;
  assign w_dbg_unused = bus.dbg_wr_req;
  assign w_dbg_gnt    = 1'b0;
`endif

  assign w_seq_gnt      = w_seq_req & ~w_csr_gnt & ~w_dbg_gnt;
  assign bus.dbg_wr_ack = w_dbg_gnt;

  always_comb begin
    w_sel_idx  = '0;
    w_sel_data = '0;
    if (w_csr_gnt) begin
      w_sel_idx  = bus.csr_wr_idx;
      w_sel_data = bus.csr_wr_data;
    end else if (w_dbg_gnt) begin
      w_sel_idx  = bus.dbg_wr_idx;
      w_sel_data = bus.dbg_wr_data;
    end else if (w_seq_gnt) begin
      w_sel_idx  = w_seq_ptr + 5'(IDX_BASE);
      w_sel_data = '0;
    end
  end

  // A granted debug write to an index below the base is acked but decodes to no register.
  assign w_sel_oh  = idx2onehot(w_sel_idx);
  assign w_wr_vld  = (w_csr_gnt | w_dbg_gnt | w_seq_gnt) & (|w_sel_oh);
  assign w_illegal = w_wr_vld &
                     (w_sel_data[HPMEVT_WIDTH-1:0] > HPMEVT_WIDTH'(HPMCNT_NUM));

  always_ff @(posedge eventx_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_evt_wen     <= '0;
      r_evt_wdata   <= '0;
      r_evt_illegal <= 1'b0;
    end else begin
      r_evt_wen     <= w_wr_vld ? w_sel_oh : '0;
      r_evt_illegal <= w_illegal;
      if (w_wr_vld) r_evt_wdata <= w_sel_data;
    end
  end

  assign bus.evt_wen     = r_evt_wen;
  assign bus.evt_clk_en  = r_evt_wen;
  assign bus.evt_wdata   = r_evt_wdata;
  assign bus.evt_illegal = r_evt_illegal;

  ct_hpcp_evt_clr_seq u_clr_seq (
    .eventx_clk (eventx_clk),
    .cpurst_b   (cpurst_b),
    .i_clr_req  (bus.clr_req),
    .i_grant    (w_seq_gnt),
    .o_req      (w_seq_req),
    .o_ptr      (w_seq_ptr),
    .o_busy     (bus.clr_busy),
    .o_done     (bus.clr_done),
    .o_state    (bus.clr_state)
  );

endmodule

// File: tb/tb_ct_hpcp_evt_ctrl.sv
// Scoreboard bench for ct_hpcp_evt_ctrl: stimulus pushes expected write-bus beats,
// a negedge monitor pops and compares every beat the DUT presents.
module tb_ct_hpcp_evt_ctrl;
  import ct_hpcp_pkg::*;

  localparam int W = EVT_NUM + 64 + 1;
`ifdef HPCP_EVT_DBG_WR_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic eventx_clk = 1'b0;
  logic cpurst_b   = 1'b0;

  ct_hpcp_evt_ctrl_if bus ();

  ct_hpcp_evt_ctrl dut (
    .eventx_clk (eventx_clk),
    .cpurst_b   (cpurst_b),
    .bus        (bus)
  );

  // ---------------- clock / reset
  always #5 eventx_clk = ~eventx_clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // ---------------- scoreboard
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;

  function automatic logic [W-1:0] beat(input int b, input logic [63:0] data, input logic ill);
    logic [EVT_NUM-1:0] oh;
    oh = EVT_NUM'(1) << b;
    return {oh, data, ill};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge eventx_clk) begin
    if (cpurst_b) begin
      checks++;
      if (bus.evt_clk_en !== bus.evt_wen) begin
        failures++;
        $display("FAIL clk_en_eq_wen got=%0h exp=%0h", bus.evt_clk_en, bus.evt_wen);
      end
      if (bus.evt_wen != '0 || bus.evt_illegal) begin
        mon_got = {bus.evt_wen, bus.evt_wdata, bus.evt_illegal};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got=%0h exp=none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL write_beat got=%0h exp=%0h", mon_got, mon_exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic step();
    @(posedge eventx_clk);
    #1;
  endtask

  task automatic csr_wr(input logic [4:0] idx, input logic [63:0] data, input int b, input logic ill);
    bus.csr_wr_vld  = 1'b1;
    bus.csr_wr_idx  = idx;
    bus.csr_wr_data = data;
    exp_q.push_back(beat(b, data, ill));
    step();
    bus.csr_wr_vld  = 1'b0;
  endtask

  task automatic push_clear(input int from_b, input int to_b);
    for (int i = from_b; i <= to_b; i++) exp_q.push_back(beat(i, 64'h0, 1'b0));
  endtask

  // Call with clr_req already driven in the current cycle; returns cycle offset of clr_done.
  task automatic wait_done(input int stall_c, output int dc);
    dc = 0;
    for (int c = 1; c <= 45; c++) begin
      step();
      bus.clr_req    = 1'b0;
      bus.csr_wr_vld = (c == stall_c);
      if (c == stall_c) begin
        bus.csr_wr_idx  = 5'd31;
        bus.csr_wr_data = 64'h5;
      end
      @(negedge eventx_clk);
      if (c == 1) check("clr_busy_start", bus.clr_busy, 1);
      if (bus.clr_done) begin
        dc = c;
        break;
      end
    end
  endtask

  int dc;

  // ---------------- stimulus
  initial begin
    bus.csr_wr_vld  = 1'b0;
    bus.csr_wr_idx  = '0;
    bus.csr_wr_data = '0;
    bus.dbg_wr_req  = 1'b0;
    bus.dbg_wr_idx  = '0;
    bus.dbg_wr_data = '0;
    bus.clr_req     = 1'b0;

    repeat (3) @(posedge eventx_clk);
    @(negedge eventx_clk);
    check("rst_wen",     bus.evt_wen,     0);
    check("rst_clk_en",  bus.evt_clk_en,  0);
    check("rst_wdata",   bus.evt_wdata,   0);
    check("rst_illegal", bus.evt_illegal, 0);
    check("rst_ack",     bus.dbg_wr_ack,  0);
    check("rst_busy",    bus.clr_busy,    0);
    check("rst_done",    bus.clr_done,    0);
    check("rst_state",   bus.clr_state,   SEQ_IDLE);
    step();
    cpurst_b = 1'b1;

    // CSR writes: decode, illegal boundary 49/50, upper data bits ignored
    csr_wr(5'd5,  64'h0A,                  2,  1'b0);
    csr_wr(5'd7,  64'h3F,                  4,  1'b1);
    csr_wr(5'd9,  64'hFFFF_0000_0000_0031, 6,  1'b0);
    csr_wr(5'd12, 64'h32,                  9,  1'b1);
    csr_wr(5'd20, 64'h400,                 17, 1'b0);
    // index below base: dropped, no beat expected
    bus.csr_wr_vld  = 1'b1;
    bus.csr_wr_idx  = 5'd2;
    bus.csr_wr_data = 64'h3F;
    step();
    bus.csr_wr_vld  = 1'b0;
    step();
    @(negedge eventx_clk);
    check("wdata_hold", bus.evt_wdata, 64'h400);
    step();

    // back-to-back CSR
    csr_wr(5'd3,  64'h1,   0,  1'b0);
    csr_wr(5'd31, 64'h2,   28, 1'b0);
    csr_wr(5'd20, 64'h3FF, 17, 1'b1);
    step();

    // CSR beats debug in the same cycle; debug acked next cycle
    bus.csr_wr_vld  = 1'b1;
    bus.csr_wr_idx  = 5'd10;
    bus.csr_wr_data = 64'h22;
    bus.dbg_wr_req  = 1'b1;
    bus.dbg_wr_idx  = 5'd3;
    bus.dbg_wr_data = 64'h11;
    exp_q.push_back(beat(7, 64'h22, 1'b0));
    if (DBG_EN) exp_q.push_back(beat(0, 64'h11, 1'b0));
    @(negedge eventx_clk);
    check("dbg_ack_lose", bus.dbg_wr_ack, 0);
    step();
    bus.csr_wr_vld = 1'b0;
    @(negedge eventx_clk);
    check("dbg_ack_win", bus.dbg_wr_ack, 64'(DBG_EN));
    step();
    bus.dbg_wr_req = 1'b0;
    @(negedge eventx_clk);
    check("dbg_ack_drop", bus.dbg_wr_ack, 0);
    step();

    // debug to index below base: acked, no write
    bus.dbg_wr_req  = 1'b1;
    bus.dbg_wr_idx  = 5'd1;
    bus.dbg_wr_data = 64'h7;
    @(negedge eventx_clk);
    check("dbg_ack_lowidx", bus.dbg_wr_ack, 64'(DBG_EN));
    step();
    bus.dbg_wr_req  = 1'b0;
    // debug illegal code
    bus.dbg_wr_req  = 1'b1;
    bus.dbg_wr_idx  = 5'd31;
    bus.dbg_wr_data = 64'h3F;
    if (DBG_EN) exp_q.push_back(beat(28, 64'h3F, 1'b1));
    step();
    bus.dbg_wr_req  = 1'b0;
    step();
    step();

    // full clear, no contention
    bus.clr_req = 1'b1;
    push_clear(0, EVT_NUM - 1);
    @(negedge eventx_clk);
    check("clr_busy_pre", bus.clr_busy, 0);
    wait_done(0, dc);
    check("clr_done_latency", dc, 30);
    step();
    @(negedge eventx_clk);
    check("clr_done_pulse", bus.clr_done, 0);
    check("clr_busy_end",   bus.clr_busy, 0);
    step();

    // clear with a CSR write stealing the slot at ptr=10
    bus.clr_req = 1'b1;
    push_clear(0, 9);
    exp_q.push_back(beat(28, 64'h5, 1'b0));
    push_clear(10, EVT_NUM - 1);
    wait_done(11, dc);
    check("clr_stall_latency", dc, 31);
    step();
    @(negedge eventx_clk);
    check("clr_stall_busy_end", bus.clr_busy, 0);
    step();

    // reset at ptr=15 aborts the clear
    bus.clr_req = 1'b1;
    push_clear(0, 14);
    for (int c = 1; c <= 16; c++) begin
      step();
      bus.clr_req = 1'b0;
      @(negedge eventx_clk);
    end
    #1 cpurst_b = 1'b0;
    #1;
    check("abort_wen",     bus.evt_wen,     0);
    check("abort_wdata",   bus.evt_wdata,   0);
    check("abort_illegal", bus.evt_illegal, 0);
    check("abort_busy",    bus.clr_busy,    0);
    check("abort_state",   bus.clr_state,   SEQ_IDLE);
    repeat (2) @(posedge eventx_clk);
    #1 cpurst_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge eventx_clk);
      check("abort_no_done", bus.clr_done, 0);
    end
    step();
    bus.clr_req = 1'b1;
    push_clear(0, EVT_NUM - 1);
    wait_done(0, dc);
    check("restart_latency", dc, 30);
    step();
    step();
    @(negedge eventx_clk);
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ct_hpcp_evt_ctrl.md
# ct_hpcp_evt_ctrl

Write controller for the bank of HPM event-select registers (mhpmevent3..31) inside the PMU. Arbitrates three write sources (CP0 CSR writes, debug-module writes, internal bulk-clear sequencer) onto the shared event-register write bus. Generates the per-register one-hot write enable and clock-gate enable consumed by each event register. Flags illegal event codes, which the event register masks to 0.

## Interface
Parameters:
- EVT_NUM, 29: number of event registers; index base 3.
- HPMEVT_WIDTH, 10: legal event-code width.
- HPMCNT_NUM, 49: largest legal event code.

Ports:
- eventx_clk  in  1  clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- csr_wr_vld  in  1  CSR write, single-cycle pulse, always accepted.
- csr_wr_idx  in  5  CSR register index (3..31).
- csr_wr_data  in  64  CSR write data.
- dbg_wr_req  in  1  debug write request; held until acknowledged.
- dbg_wr_idx  in  5  debug register index.
- dbg_wr_data  in  64  debug write data.
- dbg_wr_ack  out  1  one-cycle acknowledge.
- clr_req  in  1  start bulk clear (pulse).
- clr_busy  out  1  sequencer active.
- clr_done  out  1  one-cycle pulse at end of clear.
- evt_wen  out  EVT_NUM  one-hot write enable; bit i targets mhpmevent(i+3).
- evt_clk_en  out  EVT_NUM  clock-gate enable per register.
- evt_wdata  out  64  write data bus.
- evt_illegal  out  1  pulse: accepted write data[HPMEVT_WIDTH-1:0] > HPMCNT_NUM.

## Operation
- Fixed priority each cycle: CSR > debug > sequencer. At most one grant per cycle.
- Granted write: evt_wen, evt_clk_en, evt_wdata and evt_illegal are registered from the grant.
- Index <3: no evt_wen, no illegal flag. Debug still acked; CSR dropped.
- Debug: dbg_wr_ack asserts in the grant cycle, combinational from arbitration. The requester drops or changes dbg_wr_req after the ack cycle. A request is never acked twice.
- Sequencer FSM states:
  - IDLE: on clr_req, go to CLR with ptr=0.
  - CLR: when granted, write 0 to register ptr and increment ptr. At ptr==EVT_NUM-1 with grant, go to DONE. When not granted, stall and hold ptr.
  - DONE: assert clr_done for one cycle, then return to IDLE.
- clr_busy = (state != IDLE).
- clr_req while busy is ignored.
- CSR/debug writes during a clear take effect. Registers at index ≥ ptr are later overwritten with 0. This is defined behaviour.
- evt_illegal compares the low HPMEVT_WIDTH bits only. Upper data bits are ignored.

## Timing
- Latency: request/grant cycle N → evt_wen/evt_clk_en/evt_wdata valid in cycle N+1, for one cycle. evt_clk_en is identical to evt_wen.
- No grant → evt_wen=0, evt_clk_en=0, evt_wdata holds its last value.
- Full clear with no contention: clr_req at N → writes N+1..N+EVT_NUM → clr_done at N+EVT_NUM+1.
- Reset values:
  - evt_wen=0, evt_clk_en=0, evt_wdata=0.
  - evt_illegal=0, dbg_wr_ack=0.
  - clr_busy=0, clr_done=0.
  - FSM=IDLE, ptr=0.
- Reset mid-clear aborts the sequence. No clr_done is produced.
- Back-to-back CSR writes every cycle are supported. Debug and sequencer starve for as long as CSR writes continue.

## Configuration
- HPCP_EVT_DBG_WR_EN defined: debug port arbitrated as above.
- Undefined: dbg_wr_req/idx/data ignored, dbg_wr_ack tied 0. Arbitration is CSR > sequencer.

## Structure
- Shared package ct_hpcp_pkg holds:
  - EVT_NUM, HPMEVT_WIDTH, HPMCNT_NUM.
  - index base constant (3).
  - sequencer state encoding (IDLE/CLR/DONE).
  - index-to-one-hot decode function.
- One sub-module: ct_hpcp_evt_clr_seq. It contains the FSM, ptr, request to the arbiter, grant input, clr_busy and clr_done.
- Arbiter, decode and output registers live in the top level.

## Test plan
- CSR write idx=5, data=0x0A → cycle+1: evt_wen bit 2 only, evt_wdata=0x0A, evt_illegal=0.
- CSR write idx=7, data=0x3F (63>49) → evt_wen bit 4, evt_illegal=1 for one cycle.
- dbg_wr_req idx=3 held, CSR write idx=10 in the same cycle → CSR wins (bit 7). Next cycle dbg_wr_ack=1, then evt_wen bit 0.
- clr_req, no contention → 29 consecutive one-hot writes bits 0..28, data 0. clr_done exactly 29 cycles after the first write cycle's start, clr_busy low after.
- clr_req, then CSR write idx=31 data=0x05 when ptr=10 → sequencer stalls one cycle. Register 28 later cleared to 0. Total clear takes 30 cycles.
- Assert cpurst_b low at ptr=15 → all outputs 0, FSM IDLE, no clr_done. A new clr_req restarts from ptr=0.
